mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Request/response memory controller between the CPU datapath (MAR/MDR load path) and the 512x32 synchronous ram.
- Accepts one load or store per handshake and latches address and write data into internal MAR/MDR registers.
- Sequences the ram's single-cycle read/write strobes, captures registered read data, and returns it through a response handshake with error flagging.
- Sits directly upstream of ram; its ram_* outputs connect one-to-one to that block's read/write/addr/data_in, and ram_rdata takes ram data_out.

Parameters:
- ADDR_W, 9, ram address width; ram depth = 2**ADDR_W words.
- DATA_W, 32, data word width.
- RD_LATENCY, 1, cycles from ram_read strobe edge to data valid on ram_rdata; range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-low (0 = reset).
- req_valid  in  1  CPU request present.
- req_ready  out  1  controller can accept; equals (state==IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  word address from bus; bits [31:ADDR_W] must be 0.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  CPU consumes response.
- rsp_rdata  out  DATA_W  load data (MDR); 0 for stores and errors.
- rsp_err  out  1  address out of range.
- ram_read  out  1  ram read strobe.
- ram_write  out  1  ram write strobe.
- ram_addr  out  ADDR_W  MAR[ADDR_W-1:0].
- ram_wdata  out  DATA_W  MDR, drives ram data_in.
- ram_rdata  in  DATA_W  ram data_out.

Behaviour:
- States: IDLE, WRITE, READ, WAIT, RESP.
- Reset (clr=0, async): state=IDLE, MAR=0, MDR=0, wait counter=0, err=0. All outputs 0 except req_ready, which is 1 because it is decoded from IDLE. No acceptance while clr=0.
- Accept: in IDLE, a rising edge with req_valid=1 latches MAR<=req_addr[ADDR_W-1:0], MDR<=req_wdata (store) or 0 (load), and err<=|req_addr[31:ADDR_W].
- Next state after accept: err=1 goes to RESP with no ram strobe. Otherwise req_write=1 goes to WRITE, else READ.
- WRITE: one cycle. ram_write=1, ram_addr=MAR, ram_wdata=MDR. Next state RESP; MDR is cleared to 0 on exit.
- READ: one cycle. ram_read=1, ram_addr=MAR. Next state WAIT, counter<=RD_LATENCY-1.
- WAIT: no strobes; counter decrements each cycle. At the edge where counter==0: MDR<=ram_rdata, next state RESP.
- RESP: rsp_valid=1, rsp_rdata=MDR, rsp_err=err. Held stable until rsp_ready=1 at an edge, then IDLE.
- req_ready is 0 outside IDLE; a new request is accepted no earlier than the edge after the response handshake. No same-cycle bypass.
- ram_read and ram_write are Moore-decoded and never both 1. Each is asserted exactly one cycle per transaction.
- Latency (RD_LATENCY=1): load rsp_valid rises 3 cycles after the accept edge; store 2 cycles; error 1 cycle.
- Reset mid-transaction: immediate abort to IDLE; strobes drop asynchronously; the pending response is discarded. A store already strobed at a prior edge remains in ram.
- req_* inputs are ignored outside IDLE. Changes to req_addr/req_wdata after the accept edge have no effect.
- Address wrap: none. Any nonzero upper bit gives rsp_err=1 and rsp_rdata=0; the ram is untouched.

Test Plan:
- Store 0xDEADBEEF @ addr 0x005, then load 0x005 -> exactly one ram_write cycle with ram_addr=0x005; load rsp_valid 3 cycles after accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Load addr 0x200 -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_rdata=0; ram_read/ram_write never assert.
- Load with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable all 5 cycles; req_ready=0 throughout; returns to IDLE on the cycle after rsp_ready=1.
- Back-to-back stores to 0x000 and 0x1FF with req_valid held high -> second accept occurs 1 cycle after the first response handshake; readback of 0x1FF returns its data (boundary address).
- clr pulsed low during WAIT -> ram_read=0, rsp_valid never asserts, state IDLE, req_ready=1 after release; a following load completes normally.
- RD_LATENCY=3 build, load 0x010 holding 0x12345678 -> WAIT lasts 3 cycles, rsp_valid 5 cycles after accept, rsp_rdata=0x12345678.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: request/response controller between the CPU MAR/MDR load path
// and a 2**ADDR_W x DATA_W synchronous ram.
//
// Ports:
//   clk         system clock, rising edge
//   clr         asynchronous active-low reset
//   req_valid   CPU request present
//   req_ready   controller can accept (high only in IDLE)
//   req_write   1 = store, 0 = load
//   req_addr    32-bit word address; bits above ADDR_W must be zero
//   req_wdata   store data
//   rsp_valid   response available
//   rsp_ready   CPU consumes response
//   rsp_rdata   load data (MDR); 0 for stores and errors
//   rsp_err     address out of range
//   ram_read    ram read strobe (one cycle per load)
//   ram_write   ram write strobe (one cycle per store)
//   ram_addr    MAR, ram address
//   ram_wdata   MDR, drives ram data_in
//   ram_rdata   ram data_out
//   dbg_state_o current FSM state (IDLE=0, WRITE=1, READ=2, WAIT=3, RESP=4)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The request side is accepted only in IDLE; the response is held
// stable (rsp_valid, rsp_rdata, rsp_err) until rsp_ready is seen at an edge.

module mem_ctrl #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   mar_q, mar_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                addr_bad;

    // Any set bit above the ram address range is an error; there is no wrap.
    assign addr_bad = |req_addr[31:ADDR_W];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mar_d = req_addr[ADDR_W-1:0];
                    // MDR only carries store data for a good store, so an
                    // erroring store still answers with zero read data.
                    mdr_d = (req_write && !addr_bad) ? req_wdata : '0;
                    err_d = addr_bad;
                    if (addr_bad) begin
                        state_d = RESP;
                    end else if (req_write) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                mdr_d   = '0;
                state_d = RESP;
            end
            READ: begin
                cnt_d   = 3'(RD_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    mdr_d   = ram_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs: strobes follow the state register, so an asynchronous
    // reset drops them immediately.
    always_comb begin
        req_ready   = (state_q == IDLE);
        ram_write   = (state_q == WRITE);
        ram_read    = (state_q == READ);
        ram_addr    = mar_q;
        ram_wdata   = mdr_q;
        rsp_valid   = (state_q == RESP);
        rsp_rdata   = (state_q == RESP) ? mdr_q : '0;
        rsp_err     = (state_q == RESP) && err_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        clr;

  // main instance, RD_LATENCY = 1
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        ram_read, ram_write;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [2:0]  dbg_state;

  // second instance, RD_LATENCY = 3
  logic        r3_req_valid, r3_req_ready, r3_req_write;
  logic [31:0] r3_req_addr, r3_req_wdata;
  logic        r3_rsp_valid, r3_rsp_ready, r3_rsp_err;
  logic [31:0] r3_rsp_rdata;
  logic        r3_ram_read, r3_ram_write;
  logic [8:0]  r3_ram_addr;
  logic [31:0] r3_ram_wdata, r3_ram_rdata;
  logic [2:0]  r3_dbg_state;

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl [512];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(9), .DATA_W(32), .RD_LATENCY(1)) u_dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .dbg_state_o(dbg_state)
  );

  mem_ctrl #(.ADDR_W(9), .DATA_W(32), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .clr(clr),
    .req_valid(r3_req_valid), .req_ready(r3_req_ready), .req_write(r3_req_write),
    .req_addr(r3_req_addr), .req_wdata(r3_req_wdata),
    .rsp_valid(r3_rsp_valid), .rsp_ready(r3_rsp_ready), .rsp_rdata(r3_rsp_rdata),
    .rsp_err(r3_rsp_err),
    .ram_read(r3_ram_read), .ram_write(r3_ram_write), .ram_addr(r3_ram_addr),
    .ram_wdata(r3_ram_wdata), .ram_rdata(r3_ram_rdata), .dbg_state_o(r3_dbg_state)
  );

  // ram models: data appears RD_LATENCY cycles after the strobe edge and
  // reads as zero otherwise, so a mistimed capture shows up as wrong data.
  logic [31:0] mem1 [512];
  logic [31:0] rd1;
  always @(posedge clk) begin
    if (ram_write) mem1[ram_addr] <= ram_wdata;
    rd1 <= ram_read ? mem1[ram_addr] : 32'h0;
  end
  assign ram_rdata = rd1;

  logic [31:0] mem3 [512];
  logic [31:0] p3_0, p3_1, p3_2;
  always @(posedge clk) begin
    if (r3_ram_write) mem3[r3_ram_addr] <= r3_ram_wdata;
    p3_0 <= r3_ram_read ? mem3[r3_ram_addr] : 32'h0;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign r3_ram_rdata = p3_2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full transaction on the main instance with response hold-off.
  task automatic do_txn(input string nm, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int   lat, nr, nw;
    logic got;
    logic exp_w, exp_r;
    exp_w = wr && !exp_err;
    exp_r = !wr && !exp_err;
    @(negedge clk);
    chk({nm, ":req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 0; nr = 0; nw = 0; got = 1'b0;
    while (!got && lat < 16) begin
      @(negedge clk);
      lat++;
      chk({nm, ":strobe_excl"}, ram_read & ram_write, 0);
      if (ram_read) begin
        nr++;
        chk({nm, ":rd_addr"}, ram_addr, addr[8:0]);
      end
      if (ram_write) begin
        nw++;
        chk({nm, ":wr_addr"}, ram_addr, addr[8:0]);
        chk({nm, ":wr_data"}, ram_wdata, wd);
      end
      got = rsp_valid;
    end
    chk({nm, ":latency"}, lat, exp_lat);
    chk({nm, ":rdata"}, rsp_rdata, exp_rd);
    chk({nm, ":err"}, rsp_err, exp_err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, ":hold_valid"}, rsp_valid, 1);
      chk({nm, ":hold_rdata"}, rsp_rdata, exp_rd);
      chk({nm, ":hold_ready"}, req_ready, 0);
      chk({nm, ":hold_strobe"}, {ram_read, ram_write}, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk({nm, ":idle_ready"}, req_ready, 1);
    chk({nm, ":idle_valid"}, rsp_valid, 0);
    chk({nm, ":n_read"}, nr, exp_r);
    chk({nm, ":n_write"}, nw, exp_w);
    if (exp_w) mdl[addr[8:0]] = wd;
  endtask

  // Bounded wait for a response on the main instance, then handshake.
  task automatic wait_rsp(input string nm);
    int n;
    n = 0;
    while (!rsp_valid && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk({nm, ":rsp_seen"}, rsp_valid, 1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // Launch a load of 0x005 and pull reset at the given cycle after accept.
  task automatic rst_pulse(input string nm, input int at_lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h5; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (at_lat) @(negedge clk);
    chk({nm, ":pre_read"}, ram_read, (at_lat == 1));
    clr = 1'b0;
    #1;
    chk({nm, ":rst_read"}, ram_read, 0);
    chk({nm, ":rst_valid"}, rsp_valid, 0);
    chk({nm, ":rst_ready"}, req_ready, 1);
    #2;
    clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({nm, ":post_valid"}, rsp_valid, 0);
      chk({nm, ":post_ready"}, req_ready, 1);
      chk({nm, ":post_strobe"}, {ram_read, ram_write}, 0);
    end
  endtask

  initial begin
    logic [31:0] a, d, b_a, b_b;
    logic        w, e;
    int          lat, nwait, seen_rd;

    clr = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h5; req_wdata = 32'hFFFF_FFFF;
    rsp_ready = 1'b0;
    r3_req_valid = 1'b0; r3_req_write = 1'b0; r3_req_addr = 32'h0; r3_req_wdata = 32'h0;
    r3_rsp_ready = 1'b0;

    // ---- reset state, with req_valid asserted under reset ----
    repeat (3) @(negedge clk);
    chk("rst:req_ready", req_ready, 1);
    chk("rst:rsp_valid", rsp_valid, 0);
    chk("rst:rsp_rdata", rsp_rdata, 0);
    chk("rst:rsp_err", rsp_err, 0);
    chk("rst:ram_read", ram_read, 0);
    chk("rst:ram_write", ram_write, 0);
    chk("rst:ram_addr", ram_addr, 0);
    chk("rst:ram_wdata", ram_wdata, 0);
    req_valid = 1'b0;
    clr = 1'b1;

    // ---- table-driven vectors ----
    vecs.push_back('{1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 0, 32'h0,         1'b0, 2});
    vecs.push_back('{1'b0, 32'h0000_0005, 32'h0,         0, 32'hDEAD_BEEF, 1'b0, 3});
    vecs.push_back('{1'b0, 32'h0000_0200, 32'h0,         0, 32'h0,         1'b1, 1});
    vecs.push_back('{1'b0, 32'h0000_0005, 32'h0,         5, 32'hDEAD_BEEF, 1'b0, 3});
    vecs.push_back('{1'b1, 32'h8000_0005, 32'hCAFE_F00D, 2, 32'h0,         1'b1, 1});
    vecs.push_back('{1'b0, 32'h0000_0005, 32'h0,         0, 32'hDEAD_BEEF, 1'b0, 3});
    vecs.push_back('{1'b1, 32'h0000_01FF, 32'hA5A5_5A5A, 1, 32'h0,         1'b0, 2});
    vecs.push_back('{1'b0, 32'h0000_01FF, 32'h0,         0, 32'hA5A5_5A5A, 1'b0, 3});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'h0000_0001, 0, 32'h0,         1'b0, 2});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         0, 32'h0000_0001, 1'b0, 3});
    for (int i = 0; i < vecs.size(); i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
             vecs[i].hold, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat);
    end

    // ---- back-to-back stores with req_valid held high ----
    b_a = 32'h1111_0000;
    b_b = 32'h2222_FFFF;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_wdata = b_a;
    @(posedge clk); #1;
    req_addr = 32'h1FF; req_wdata = b_b;
    @(negedge clk);
    chk("b2b:wr1", ram_write, 1);
    chk("b2b:wr1_addr", ram_addr, 9'h000);
    chk("b2b:wr1_data", ram_wdata, b_a);
    wait_rsp("b2b:rsp1");
    @(negedge clk);
    chk("b2b:gap_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b:acc2_ready", req_ready, 0);
    chk("b2b:wr2", ram_write, 1);
    chk("b2b:wr2_addr", ram_addr, 9'h1FF);
    chk("b2b:wr2_data", ram_wdata, b_b);
    wait_rsp("b2b:rsp2");
    mdl[0] = b_a;
    mdl[9'h1FF] = b_b;
    do_txn("b2b:ld1ff", 1'b0, 32'h1FF, 32'h0, 0, b_b, 1'b0, 3);
    do_txn("b2b:ld000", 1'b0, 32'h000, 32'h0, 0, b_a, 1'b0, 3);

    // ---- reset mid-transaction ----
    rst_pulse("rst_wait", 2);
    do_txn("rst_wait:ld", 1'b0, 32'h5, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 3);
    rst_pulse("rst_read", 1);
    do_txn("rst_read:ld", 1'b0, 32'h5, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 3);

    // ---- RD_LATENCY = 3 instance: store then load 0x010 ----
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      r3_req_valid = 1'b1; r3_req_write = (k == 0); r3_req_addr = 32'h10;
      r3_req_wdata = 32'h1234_5678;
      @(posedge clk); #1;
      r3_req_valid = 1'b0;
      lat = 0; nwait = 0; seen_rd = 0;
      while (!r3_rsp_valid && lat < 16) begin
        @(negedge clk);
        lat++;
        if (seen_rd != 0 && !r3_rsp_valid) nwait++;
        if (r3_ram_read) seen_rd = 1;
      end
      chk($sformatf("lat3_%0d:latency", k), lat, (k == 0) ? 2 : 5);
      chk($sformatf("lat3_%0d:wait_cycles", k), nwait, (k == 0) ? 0 : 3);
      chk($sformatf("lat3_%0d:rdata", k), r3_rsp_rdata, (k == 0) ? 32'h0 : 32'h1234_5678);
      chk($sformatf("lat3_%0d:err", k), r3_rsp_err, 0);
      r3_rsp_ready = 1'b1;
      @(posedge clk); #1;
      r3_rsp_ready = 1'b0;
    end

    // ---- randomized traffic against the transaction-level model ----
    for (int i = 0; i < 16; i++) begin
      a = (i < 8) ? 32'(i) : 32'(32'h1F8 + i - 8);
      d = $urandom;
      do_txn($sformatf("prime%0d", i), 1'b1, a, d, 0, 32'h0, 1'b0, 2);
    end
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 1) != 0) ? 32'h1F8 : 32'h0;
      a = a + 32'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) a = a | (32'h1 << $urandom_range(9, 31));
      d = $urandom;
      e = (a[31:9] != 23'h0);
      do_txn($sformatf("rnd%0d", i), w, a, d, $urandom_range(0, 3),
             (e || w) ? 32'h0 : mdl[a[8:0]], e, e ? 1 : (w ? 2 : 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
